// File: rtl/acc_pkg.sv
// Shared accelerator types: register/data types, writeback entry and match helper.
// Used by acc_wb_buffer (optional forwarding build: ACC_WB_FWD_EN).
package acc_pkg;

  localparam int ACC_AW       = 5;
  localparam int ACC_DW       = 32;
  localparam int ACC_WB_DEPTH = 4;

  typedef logic [ACC_AW-1:0] reg_addr_t;
  typedef logic [ACC_DW-1:0] data_t;

  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } wb_entry_t;

  // x0 never hazards, so a zero source address never matches
  function automatic logic wb_match(
    input wb_entry_t e,
    input logic      v,
    input reg_addr_t a
  );
    return v && (a != '0) && (e.addr == a);
  endfunction

endpackage

// File: rtl/acc_wb_buffer.sv
// In-order writeback queue between acc_top and the CPU regfile write port.
// Define ACC_WB_FWD_EN to add fwd_data_o (newest matching entry per check port).
module acc_wb_buffer
  import acc_pkg::*;
#(
  parameter int DEPTH = ACC_WB_DEPTH,
  parameter int AW    = ACC_AW,
  parameter int DW    = ACC_DW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AW-1:0]        acc_waddr_i,
  input  logic [DW-1:0]        acc_wdata_i,
  input  logic                 acc_wren_i,
  output logic                 acc_ready_o,
  input  logic                 cpu_wb_busy_i,
  output logic [AW-1:0]        rf_waddr_o,
  output logic [DW-1:0]        rf_wdata_o,
  output logic                 rf_wren_o,
  input  logic [2:0][AW-1:0]   chk_addr_i,
  output logic [2:0]           hit_o,
`ifdef ACC_WB_FWD_EN
  output logic [2:0][DW-1:0]   fwd_data_o,
`endif
  output logic                 empty_o,
  output logic                 overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic      ready;
  logic      push;
  logic      pop;
  wb_entry_t head;
  wb_entry_t wentry;

  assign ready  = !rst_i && (count_q < CW'(DEPTH));
  assign head   = mem_q[rd_ptr_q];
  assign pop    = vld_q[rd_ptr_q] && !cpu_wb_busy_i && !rst_i;
  assign push   = acc_wren_i && ready && (acc_waddr_i != '0);
  assign wentry = '{addr: reg_addr_t'(acc_waddr_i),
                    data: data_t'(acc_wdata_i)};

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (acc_wren_i && !ready);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // payload needs no reset; validity lives in vld_q
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wentry;
  end

  assign acc_ready_o = ready;
  assign rf_wren_o   = pop;
  assign rf_waddr_o  = pop ? AW'(head.addr) : '0;
  assign rf_wdata_o  = pop ? DW'(head.data) : '0;
  assign empty_o     = (count_q == '0);
  assign overflow_o  = ovf_q;

  always_comb begin
    hit_o = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hit_o[k] = hit_o[k] |
          wb_match(mem_q[i], vld_q[i], reg_addr_t'(chk_addr_i[k]));
      end
    end
  end

`ifdef ACC_WB_FWD_EN
  // walk oldest to newest so the youngest match wins
  always_comb begin
    logic [PW-1:0] idx;
    fwd_data_o = '0;
    idx        = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if (wb_match(mem_q[idx], vld_q[idx],
                     reg_addr_t'(chk_addr_i[k])))
          fwd_data_o[k] = DW'(mem_q[idx].data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_acc_wb_buffer.sv
// Directed self-checking bench for acc_wb_buffer.
// Build with ACC_WB_FWD_EN to also check fwd_data_o.
module tb_acc_wb_buffer;

  logic             clk;
  logic             rst;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic             wren;
  logic             ready;
  logic             busy;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             rf_wren;
  logic [2:0][4:0]  chk;
  logic [2:0]       hit;
  logic             empty;
  logic             ovf;
`ifdef ACC_WB_FWD_EN
  logic [2:0][31:0] fwd;
`endif

  int checks   = 0;
  int failures = 0;

  acc_wb_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .acc_waddr_i   (waddr),
    .acc_wdata_i   (wdata),
    .acc_wren_i    (wren),
    .acc_ready_o   (ready),
    .cpu_wb_busy_i (busy),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_wren_o     (rf_wren),
    .chk_addr_i    (chk),
    .hit_o         (hit),
`ifdef ACC_WB_FWD_EN
    .fwd_data_o    (fwd),
`endif
    .empty_o       (empty),
    .overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    waddr = a;
    wdata = d;
    wren  = 1'b1;
    step();
    wren  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (rf_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_wren got=%0b exp=0", rf_wren);
    end
    checks++;
    if (empty !== 1'b1 || ovf !== 1'b0 || hit !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags empty=%0b ovf=%0b hit=%b exp 1/0/000",
               empty, ovf, hit);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_in_rst got=%0b exp=0", ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got=%0b exp=1", ready);
    end
  endtask

  task automatic test_single();
    busy = 1'b0;
    checks++;
    if (rf_wren !== 1'b0) begin
      failures++;
      $display("FAIL single_no_bypass got=%0b exp=0", rf_wren);
    end
    push(5'd1, 32'h4040_0000);
    checks++;
    if (rf_wren !== 1'b1 || rf_waddr !== 5'd1 ||
        rf_wdata !== 32'h4040_0000) begin
      failures++;
      $display("FAIL single_write wren=%0b a=%0d d=%h exp 1/1/40400000",
               rf_wren, rf_waddr, rf_wdata);
    end
    // push x2 while x1 retires: count stays at one
    push(5'd2, 32'h0000_0022);
    checks++;
    if (rf_wren !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22
        || empty !== 1'b0) begin
      failures++;
      $display("FAIL single_pushpop wren=%0b a=%0d d=%h empty=%0b",
               rf_wren, rf_waddr, rf_wdata, empty);
    end
    step();
    checks++;
    if (empty !== 1'b1 || rf_wren !== 1'b0 || rf_waddr !== 5'd0 ||
        rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL single_empty empty=%0b wren=%0b a=%0d d=%h",
               empty, rf_wren, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_fill();
    logic [4:0] exp_a [4];
    exp_a = '{5'd1, 5'd7, 5'd3, 5'd4};
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(exp_a[i], 32'h100 + 32'(exp_a[i]));
    checks++;
    if (ready !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL fill_full ready=%0b ovf=%0b exp 0/0", ready, ovf);
    end
    push(5'd9, 32'h999);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow got=%0b exp=1", ovf);
    end
    busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rf_wren !== 1'b1 || rf_waddr !== exp_a[i] ||
          rf_wdata !== 32'h100 + 32'(exp_a[i])) begin
        failures++;
        $display("FAIL fill_drain%0d wren=%0b a=%0d d=%h exp a=%0d",
                 i, rf_wren, rf_waddr, rf_wdata, exp_a[i]);
      end
      step();
    end
    checks++;
    if (rf_wren !== 1'b0 || empty !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL fill_after wren=%0b empty=%0b ovf=%0b exp 0/1/1",
               rf_wren, empty, ovf);
    end
  endtask

  task automatic test_waw();
    logic [31:0] reg7;
    reg7 = 32'h0;
    busy = 1'b1;
    chk  = '0;
    chk[0] = 5'd7;
    chk[2] = 5'd3;
    push(5'd7, 32'h4150_0000);
    push(5'd7, 32'h3F80_0000);
    checks++;
    if (hit !== 3'b001) begin
      failures++;
      $display("FAIL waw_hit got=%b exp=001", hit);
    end
`ifdef ACC_WB_FWD_EN
    checks++;
    if (fwd[0] !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL waw_fwd got=%h exp=3f800000", fwd[0]);
    end
`endif
    busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rf_wren === 1'b1 && rf_waddr === 5'd7) reg7 = rf_wdata;
      step();
    end
    checks++;
    if (reg7 !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL waw_final got=%h exp=3f800000", reg7);
    end
    checks++;
    if (hit !== 3'b000 || empty !== 1'b1) begin
      failures++;
      $display("FAIL waw_cleared hit=%b empty=%0b exp 000/1", hit, empty);
    end
  endtask

  task automatic test_zero();
    busy = 1'b0;
    chk  = '0;
    push(5'd0, 32'hDEAD_BEEF);
    checks++;
    if (rf_wren !== 1'b0 || empty !== 1'b1 || hit !== 3'b000) begin
      failures++;
      $display("FAIL zero_discard wren=%0b empty=%0b hit=%b exp 0/1/000",
               rf_wren, empty, hit);
    end
  endtask

  task automatic test_full_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL fr_ovf_clear got=%0b exp=0", ovf);
    end
    busy = 1'b1;
    for (int i = 2; i < 6; i++) push(5'(i), 32'(i));
    busy  = 1'b0;
    waddr = 5'd6;
    wdata = 32'h6;
    wren  = 1'b1;
    #1;
    checks++;
    if (rf_wren !== 1'b1 || rf_waddr !== 5'd2 || ready !== 1'b0) begin
      failures++;
      $display("FAIL fr_pop_full wren=%0b a=%0d ready=%0b exp 1/2/0",
               rf_wren, rf_waddr, ready);
    end
    step();
    wren = 1'b0;
    #1;
    checks++;
    if (ovf !== 1'b1 || rf_waddr !== 5'd3 || ready !== 1'b1) begin
      failures++;
      $display("FAIL fr_refused ovf=%0b a=%0d ready=%0b exp 1/3/1",
               ovf, rf_waddr, ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rf_wren !== 1'b0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL fr_dropped%0d wren=%0b empty=%0b exp 0/1",
                 i, rf_wren, empty);
      end
      step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    waddr = '0;
    wdata = '0;
    wren  = 1'b0;
    busy  = 1'b0;
    chk   = '0;
    test_reset();
    test_single();
    test_fill();
    test_waw();
    test_zero();
    test_full_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
